// File: rtl/array_c_writeback_generator_pkg.sv
// ============================================================================
// Module   : matrix_mult_pkg
// Brief    : Shared types and constants for the matrix-multiply datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package matrix_mult_pkg;

  localparam int DIM_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/array_c_writeback_generator_c_tile_counter.sv
// ============================================================================
// Module   : c_tile_counter
// Brief    : Tile-order beat counters and C buffer address generation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module c_tile_counter
  import matrix_mult_pkg::*;
#(
  parameter int ARRAY_HEIGHT         = 4,
  parameter int BUFFER_ADDRESS_WIDTH = 10
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            load,
  input  logic                            advance,
  input  logic [DIM_WIDTH-1:0]            tc,
  input  logic [DIM_WIDTH-1:0]            tr,
  output logic                            last_beat,
  output logic [BUFFER_ADDRESS_WIDTH-1:0] addr
);

  localparam int LOG_H = $clog2(ARRAY_HEIGHT);
  localparam int RW    = (LOG_H > 0) ? LOG_H : 1;
  localparam logic [RW-1:0] R_MAX = RW'(ARRAY_HEIGHT - 1);

  logic [DIM_WIDTH-1:0]            r_tc;
  logic [DIM_WIDTH-1:0]            r_tr;
  logic [RW-1:0]                   r_row_idx;
  logic [DIM_WIDTH-1:0]            r_tile_col;
  logic [DIM_WIDTH-1:0]            r_tile_row;
  logic [BUFFER_ADDRESS_WIDTH-1:0] r_r_offset;
  logic [BUFFER_ADDRESS_WIDTH-1:0] r_tile_row_base;

  logic                            w_r_wrap;
  logic                            w_col_wrap;
  logic                            w_row_wrap;
  logic [BUFFER_ADDRESS_WIDTH-1:0] w_tc_addr;
  logic [BUFFER_ADDRESS_WIDTH-1:0] w_row_step;

  assign w_r_wrap   = (r_row_idx == R_MAX);
  assign w_col_wrap = (r_tile_col == r_tc - DIM_WIDTH'(1));
  assign w_row_wrap = (r_tile_row == r_tr - DIM_WIDTH'(1));

  // Strides are built from shifts and adds only; everything wraps at the buffer size.
  assign w_tc_addr  = BUFFER_ADDRESS_WIDTH'(r_tc);
  assign w_row_step = w_tc_addr << LOG_H;

  assign last_beat = w_r_wrap & w_col_wrap & w_row_wrap;
  assign addr      = r_tile_row_base + r_r_offset + BUFFER_ADDRESS_WIDTH'(r_tile_col);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tc            <= '0;
      r_tr            <= '0;
      r_row_idx       <= '0;
      r_tile_col      <= '0;
      r_tile_row      <= '0;
      r_r_offset      <= '0;
      r_tile_row_base <= '0;
    end else if (load) begin
      r_tc            <= tc;
      r_tr            <= tr;
      r_row_idx       <= '0;
      r_tile_col      <= '0;
      r_tile_row      <= '0;
      r_r_offset      <= '0;
      r_tile_row_base <= '0;
    end else if (advance) begin
      if (w_r_wrap) begin
        r_row_idx  <= '0;
        r_r_offset <= '0;
        if (w_col_wrap) begin
          r_tile_col      <= '0;
          r_tile_row_base <= r_tile_row_base + w_row_step;
          r_tile_row      <= w_row_wrap ? '0 : r_tile_row + DIM_WIDTH'(1);
        end else begin
          r_tile_col <= r_tile_col + DIM_WIDTH'(1);
        end
      end else begin
        r_row_idx  <= r_row_idx + RW'(1);
        r_r_offset <= r_r_offset + w_tc_addr;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/array_c_writeback_generator.sv
// ============================================================================
// Module   : array_c_writeback_generator
// Brief    : Drains systolic array result rows into the C buffer in tile order.
//            Optional sticky protocol error flag: define C_WRITEBACK_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module array_c_writeback_generator
  import matrix_mult_pkg::*;
#(
  parameter int ARRAY_HEIGHT         = 4,
  parameter int ARRAY_WIDTH          = 4,
  parameter int DATA_WIDTH           = 32,
  parameter int BUFFER_ADDRESS_WIDTH = 10
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start_i,
  input  logic [DIM_WIDTH-1:0]                m,
  input  logic [DIM_WIDTH-1:0]                p,
  input  logic                                res_valid_i,
  input  logic [ARRAY_WIDTH*DATA_WIDTH-1:0]   res_data_i,
  output logic                                res_ready_o,
  output logic                                c_we,
  output logic [BUFFER_ADDRESS_WIDTH-1:0]     c_addr,
  output logic [ARRAY_WIDTH*DATA_WIDTH-1:0]   c_data,
  input  logic                                c_wready_i,
  output logic                                busy_o,
  output logic                                done
`ifdef C_WRITEBACK_ERR_EN
  ,
  output logic                                err_o
`endif
);

  localparam int LOG_W = $clog2(ARRAY_WIDTH);
  localparam int LOG_H = $clog2(ARRAY_HEIGHT);

  wb_state_t                       r_state;
  wb_state_t                       w_state_next;
  logic [DIM_WIDTH-1:0]            w_tc;
  logic [DIM_WIDTH-1:0]            w_tr;
  logic                            w_start_acc;
  logic                            w_beat_acc;
  logic                            w_last_beat;
  logic [BUFFER_ADDRESS_WIDTH-1:0] w_addr;

  assign w_tc        = p >> LOG_W;
  assign w_tr        = m >> LOG_H;
  assign w_start_acc = (r_state == IDLE) & start_i;
  assign res_ready_o = (r_state == RUN) & (~c_we | c_wready_i);
  assign w_beat_acc  = res_valid_i & res_ready_o;
  assign busy_o      = (r_state == RUN) | (r_state == FLUSH);
  assign done        = (r_state == DONE);

  c_tile_counter #(
    .ARRAY_HEIGHT         (ARRAY_HEIGHT),
    .BUFFER_ADDRESS_WIDTH (BUFFER_ADDRESS_WIDTH)
  ) u_tile_counter (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (w_start_acc),
    .advance   (w_beat_acc),
    .tc        (w_tc),
    .tr        (w_tr),
    .last_beat (w_last_beat),
    .addr      (w_addr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_next = ((w_tc == '0) || (w_tr == '0)) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_beat_acc && w_last_beat) begin
          w_state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (!c_we || c_wready_i) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // A new beat may reload the register in the same cycle the held write retires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_we   <= 1'b0;
      c_addr <= '0;
      c_data <= '0;
    end else if (w_beat_acc) begin
      c_we   <= 1'b1;
      c_addr <= w_addr;
      c_data <= res_data_i;
    end else if (c_we && c_wready_i) begin
      c_we   <= 1'b0;
    end
  end

`ifdef C_WRITEBACK_ERR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_o <= 1'b0;
    end else if (w_start_acc) begin
      err_o <= 1'b0;
    end else if (res_valid_i && ((r_state == IDLE) || (r_state == DONE))) begin
      err_o <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_array_c_writeback_generator.sv
// ============================================================================
// Module   : tb_array_c_writeback_generator
// Brief    : Directed self-checking bench with a tile-order write model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_array_c_writeback_generator;

  localparam int H   = 4;
  localparam int W   = 4;
  localparam int DWE = 32;
  localparam int DW  = W * DWE;
  localparam int AW  = 10;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk;
  logic          reset_n;
  logic          start_i;
  logic [15:0]   m;
  logic [15:0]   p;
  logic          res_valid_i;
  logic [DW-1:0] res_data_i;
  logic          res_ready_o;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_data;
  logic          c_wready_i;
  logic          busy_o;
  logic          done;
`ifdef C_WRITEBACK_ERR_EN
  logic          err_o;
`endif

  array_c_writeback_generator #(
    .ARRAY_HEIGHT         (H),
    .ARRAY_WIDTH          (W),
    .DATA_WIDTH           (DWE),
    .BUFFER_ADDRESS_WIDTH (AW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_i     (start_i),
    .m           (m),
    .p           (p),
    .res_valid_i (res_valid_i),
    .res_data_i  (res_data_i),
    .res_ready_o (res_ready_o),
    .c_we        (c_we),
    .c_addr      (c_addr),
    .c_data      (c_data),
    .c_wready_i  (c_wready_i),
    .busy_o      (busy_o),
    .done        (done)
`ifdef C_WRITEBACK_ERR_EN
    ,
    .err_o       (err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            negcyc = 0;
  int            done_cnt = 0;
  int            done_neg = 0;
  bit            mon_en = 0;
  bit            hold_pend = 0;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_data;
  wr_t           exp_q[$];
  logic [AW-1:0] act_addrs[$];
  logic [AW-1:0] lit_addr [16] = '{10'd0, 10'd2, 10'd4, 10'd6, 10'd1, 10'd3, 10'd5, 10'd7,
                                   10'd8, 10'd10, 10'd12, 10'd14, 10'd9, 10'd11, 10'd13, 10'd15};

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] make_data(input int k);
    logic [DW-1:0] d;
    for (int j = 0; j < W; j++) d[j*DWE +: DWE] = 32'hC0DE_0000 + 32'(k * 16 + j);
    return d;
  endfunction

  // Expected writes: C row (tile_row*H + r), word column tile_col, row pitch TC words.
  task automatic build_model(input int mm, input int pp);
    int tcn, trn, k;
    wr_t e;
    tcn = pp / W;
    trn = mm / H;
    k = 0;
    exp_q.delete();
    for (int trw = 0; trw < trn; trw++)
      for (int tcl = 0; tcl < tcn; tcl++)
        for (int r = 0; r < H; r++) begin
          e.addr = AW'((trw * H + r) * tcn + tcl);
          e.data = make_data(k);
          exp_q.push_back(e);
          k++;
        end
  endtask

  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      negcyc++;
      #3;
      if (!mon_en) begin
        hold_pend = 0;
      end else begin
        if (done) begin
          done_cnt++;
          done_neg = negcyc;
        end
        if (hold_pend) begin
          chk("hold_we", DW'(c_we), DW'(1));
          chk("hold_addr", DW'(c_addr), DW'(hold_addr));
          chk("hold_data", c_data, hold_data);
        end
        if (c_we && !c_wready_i) begin
          chk("stall_ready", DW'(res_ready_o), DW'(0));
          hold_pend = 1;
          hold_addr = c_addr;
          hold_data = c_data;
        end else begin
          hold_pend = 0;
        end
        if (c_we && c_wready_i) begin
          if (exp_q.size() == 0) begin
            chk("extra_write", DW'(c_addr), DW'(1023));
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", DW'(c_addr), DW'(e.addr));
            chk("wr_data", c_data, e.data);
          end
          act_addrs.push_back(c_addr);
        end
      end
    end
  end

  task automatic check_lit_addrs();
    chk("addr_count", DW'(act_addrs.size()), DW'(16));
    for (int i = 0; i < 16 && i < act_addrs.size(); i++)
      chk("addr_seq", DW'(act_addrs[i]), DW'(lit_addr[i]));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_c_we"}, DW'(c_we), DW'(0));
    chk({tag, "_c_addr"}, DW'(c_addr), DW'(0));
    chk({tag, "_c_data"}, c_data, DW'(0));
    chk({tag, "_ready"}, DW'(res_ready_o), DW'(0));
    chk({tag, "_busy"}, DW'(busy_o), DW'(0));
    chk({tag, "_done"}, DW'(done), DW'(0));
  endtask

  task automatic run_stream(input int mm, input int pp, input int stall_at,
                            input int restart_at, input int reset_after);
    int  total, k, guard, stall_left, acc_neg;
    bit  stalled, restarted, acc;
    build_model(mm, pp);
    total = exp_q.size();
    act_addrs.delete();
    done_cnt = 0;
    @(negedge clk);
    m = 16'(mm);
    p = 16'(pp);
    start_i = 1;
    @(negedge clk);
    start_i = 0;
    k = 0; guard = 0; stall_left = 0; acc_neg = 0;
    stalled = 0; restarted = 0;
    res_valid_i = 1;
    res_data_i  = make_data(0);
    while (k < total && guard < 400) begin
      start_i = 0;
      if (restart_at >= 0 && k == restart_at && !restarted) begin
        start_i = 1;
        m = 16'd4;
        p = 16'd4;
        restarted = 1;
      end
      c_wready_i = 1;
      if (stall_left > 0) begin
        c_wready_i = 0;
        stall_left--;
      end else if (stall_at > 0 && !stalled && c_we && act_addrs.size() == stall_at - 1) begin
        c_wready_i = 0;
        stall_left = 2;
        stalled = 1;
        #1 chk("stall_addr", DW'(c_addr), DW'(lit_addr[stall_at-1]));
      end
      #1;
      acc = res_valid_i && res_ready_o;
      if (acc) acc_neg = negcyc;
      @(posedge clk);
      #1;
      if (acc) k++;
      if (reset_after > 0 && k == reset_after) begin
        mon_en = 0;
        res_valid_i = 0;
        reset_n = 0;
        #1 check_all_zero("mid_reset");
        exp_q.delete();
        @(negedge clk);
        reset_n = 1;
        mon_en = 1;
        return;
      end
      res_data_i  = make_data(k);
      res_valid_i = (k < total);
      @(negedge clk);
      guard++;
    end
    start_i = 0;
    c_wready_i = 1;
    res_valid_i = 0;
    chk("stream_beats", DW'(k), DW'(total));
    guard = 0;
    while (done_cnt == 0 && guard < 50) begin
      @(negedge clk);
      #4;
      guard++;
    end
    chk("done_latency", DW'(done_neg - acc_neg), DW'(2));
    chk("queue_empty", DW'(exp_q.size()), DW'(0));
    @(negedge clk);
    #4;
    chk("busy_after", DW'(busy_o), DW'(0));
    chk("done_once", DW'(done_cnt), DW'(1));
  endtask

  initial begin
    int s_neg, guard;
    reset_n = 0; start_i = 0; m = '0; p = '0;
    res_valid_i = 0; res_data_i = '0; c_wready_i = 1;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1;
    mon_en = 1;

    run_stream(8, 8, -1, -1, 0);
    check_lit_addrs();

    run_stream(8, 8, 5, -1, 0);
    check_lit_addrs();

    run_stream(8, 8, -1, 5, 0);
    check_lit_addrs();

    // TR == 0: straight to DONE without any write.
    exp_q.delete();
    act_addrs.delete();
    done_cnt = 0;
    @(negedge clk);
    m = 16'd2; p = 16'd8; start_i = 1;
    #1 s_neg = negcyc;
    @(negedge clk);
    start_i = 0;
    guard = 0;
    while (done_cnt == 0 && guard < 50) begin
      @(negedge clk);
      #4;
      guard++;
    end
    chk("empty_done_latency", DW'(done_neg - s_neg), DW'(1));
    chk("empty_no_writes", DW'(act_addrs.size()), DW'(0));
    @(negedge clk);

    run_stream(8, 8, -1, -1, 7);
    run_stream(8, 8, -1, -1, 0);
    check_lit_addrs();
    chk("restart_addr0", DW'(act_addrs.size() > 0 ? act_addrs[0] : AW'(1023)), DW'(0));

`ifdef C_WRITEBACK_ERR_EN
    @(negedge clk);
    chk("err_idle_clear", DW'(err_o), DW'(0));
    res_valid_i = 1;
    @(negedge clk);
    res_valid_i = 0;
    #1 chk("err_set", DW'(err_o), DW'(1));
    m = 16'd2; p = 16'd8; start_i = 1;
    @(negedge clk);
    start_i = 0;
    #1 chk("err_clear", DW'(err_o), DW'(0));
    repeat (3) @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
